// File: rtl/fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fb_pkg : shared framebuffer write-port types and constants          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fb_pkg;
  localparam int H_PIX   = 640;
  localparam int V_PIX   = 480;
  localparam int COORD_W = 11;
  localparam int PIX_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CLEAR   = 2'd2
  } fbw_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [PIX_W-1:0]   gs;
  } pixel_wr_t;
endpackage
`default_nettype wire

// File: rtl/fb_write_scheduler_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot arbiter, search from last grant+1  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int c_PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int c_SUM_W = c_PTR_W + 1;

  logic [c_PTR_W-1:0] r_last_grant;
  logic [c_PTR_W-1:0] w_grant_idx;
  logic [c_PTR_W-1:0] w_idx;
  logic [c_SUM_W-1:0] w_sum;
  logic               w_found;

  always_comb begin
    grant       = '0;
    w_grant_idx = r_last_grant;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int i = 1; i <= N; i++) begin
      // modulo-N wrap without a divider
      w_sum = {1'b0, r_last_grant} + c_SUM_W'(i);
      if (w_sum >= c_SUM_W'(N)) w_sum = w_sum - c_SUM_W'(N);
      w_idx = w_sum[c_PTR_W-1:0];
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_grant_idx  = w_idx;
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      r_last_grant <= c_PTR_W'(N - 1);
    else if (advance && w_found)
      r_last_grant <= w_grant_idx;
  end
endmodule
`default_nettype wire

// File: rtl/fb_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fb_write_scheduler : arbitrates framebuffer pixel writes, clears    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fb_write_scheduler #(
  parameter int         NREQ        = 3,
  parameter int         H_PIX       = 640,
  parameter int         V_PIX       = 480,
  parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*fb_pkg::COORD_W-1:0] req_x,
  input  logic [NREQ*fb_pkg::COORD_W-1:0] req_y,
  input  logic [NREQ*fb_pkg::PIX_W-1:0]   req_pixel,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         clear_req,
  input  logic                         clear_sync,
  input  logic                         vga_vs_n,
  output logic                         clear_busy,
  output logic [fb_pkg::COORD_W-1:0]   x,
  output logic [fb_pkg::COORD_W-1:0]   y,
  output logic [fb_pkg::PIX_W-1:0]     pixel_GS,
  output logic                         pixel_write,
  output logic [15:0]                  oob_count
);
  import fb_pkg::*;

  localparam logic [COORD_W-1:0] c_LAST_X = COORD_W'(H_PIX - 1);
  localparam logic [COORD_W-1:0] c_LAST_Y = COORD_W'(V_PIX - 1);

  fbw_state_t         r_state, w_state_nxt;
  logic [NREQ-1:0]    w_grant;
  logic               w_xfer;
  logic               w_oob;
  logic               w_clear_last;
  logic               r_vs_n;
  logic [COORD_W-1:0] r_cx, r_cy;
  pixel_wr_t          w_sel;

  rr_arbiter #(.N(NREQ)) u_arb (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req      (req_valid),
    .advance  (w_xfer),
    .grant    (w_grant)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel.x  = req_x[i*COORD_W +: COORD_W];
        w_sel.y  = req_y[i*COORD_W +: COORD_W];
        w_sel.gs = req_pixel[i*PIX_W +: PIX_W];
      end
    end
  end

  assign w_oob        = (w_sel.x >= COORD_W'(H_PIX)) || (w_sel.y >= COORD_W'(V_PIX));
  assign w_clear_last = (r_cx == c_LAST_X) && (r_cy == c_LAST_Y);
  assign w_xfer       = |req_ready;
  assign clear_busy   = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (clear_req) w_state_nxt = clear_sync ? WAIT_VS : CLEAR;
      end
      WAIT_VS: if (r_vs_n && !vga_vs_n) w_state_nxt = CLEAR;
      CLEAR:   if (w_clear_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_vs_n      <= 1'b0;
      r_cx        <= '0;
      r_cy        <= '0;
      x           <= '0;
      y           <= '0;
      pixel_GS    <= '0;
      pixel_write <= 1'b0;
      oob_count   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_vs_n      <= vga_vs_n;
      pixel_write <= 1'b0;
      if (r_state == IDLE && w_xfer) begin
        // out-of-range pixels are consumed but never reach the framebuffer
        if (w_oob) begin
          if (oob_count != 16'hFFFF) oob_count <= oob_count + 16'd1;
        end else begin
          x           <= w_sel.x;
          y           <= w_sel.y;
          pixel_GS    <= w_sel.gs;
          pixel_write <= 1'b1;
        end
      end else if (r_state == CLEAR) begin
        x           <= r_cx;
        y           <= r_cy;
        pixel_GS    <= CLEAR_VALUE;
        pixel_write <= 1'b1;
        if (r_cx == c_LAST_X) begin
          r_cx <= '0;
          r_cy <= (r_cy == c_LAST_Y) ? '0 : r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fb_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fb_write_scheduler : randomized scoreboard bench                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_fb_write_scheduler;
  localparam int         NREQ = 3;
  localparam int         H_T  = 40;
  localparam int         V_T  = 30;
  localparam logic [7:0] CV   = 8'h3C;
  localparam int M_IDLE = 0, M_WAIT = 1, M_CLEAR = 2;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*11-1:0]   req_x, req_y;
  logic [NREQ*8-1:0]    req_pixel;
  logic [NREQ-1:0]      req_ready;
  logic                 clear_req, clear_sync, vga_vs_n, clear_busy;
  logic [10:0]          x, y;
  logic [7:0]           pixel_GS;
  logic                 pixel_write;
  logic [15:0]          oob_count;

  typedef struct {int x; int y; int gs; longint cyc;} exp_t;
  exp_t   q[$];
  exp_t   e_mon;
  int     n_tests = 0, n_fail = 0;
  longint cyc = 0;
  int     m_mode, m_last, m_oob, m_left;
  logic   m_vs_prev;

  fb_write_scheduler #(.NREQ(NREQ), .H_PIX(H_T), .V_PIX(V_T), .CLEAR_VALUE(CV)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_pixel(req_pixel), .req_ready(req_ready), .clear_req(clear_req), .clear_sync(clear_sync),
    .vga_vs_n(vga_vs_n), .clear_busy(clear_busy), .x(x), .y(y), .pixel_GS(pixel_GS),
    .pixel_write(pixel_write), .oob_count(oob_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input int vx, input int vy, input int pg);
    req_x[i*11 +: 11]   = 11'(vx);
    req_y[i*11 +: 11]   = 11'(vy);
    req_pixel[i*8 +: 8] = 8'(pg);
  endtask

  task automatic start_clear(input longint first);
    for (int cy = 0; cy < V_T; cy++)
      for (int cx = 0; cx < H_T; cx++)
        q.push_back('{cx, cy, int'(CV), first + longint'(cy * H_T + cx)});
    m_mode = M_CLEAR;
    m_left = H_T * V_T;
  endtask

  // One clock of the reference model; entered just after a rising edge.
  task automatic step();
    int g;
    int gx, gy, gp;
    @(negedge CLOCK_50);
    chk("oob_count", oob_count, m_oob);
    if (m_mode == M_IDLE) begin
      g = -1;
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
      chk("clear_busy_idle", clear_busy, 0);
      if (g >= 0) begin
        gx = int'(req_x[g*11 +: 11]);
        gy = int'(req_y[g*11 +: 11]);
        gp = int'(req_pixel[g*8 +: 8]);
        if (gx < H_T && gy < V_T) q.push_back('{gx, gy, gp, cyc + 1});
        else if (m_oob < 65535) m_oob++;
        m_last = g;
      end
      if (clear_req) begin
        if (clear_sync) m_mode = M_WAIT;
        else start_clear(cyc + 2);
      end
    end else begin
      chk("req_ready_busy", req_ready, 0);
      chk("clear_busy", clear_busy, 1);
      if (m_mode == M_WAIT) begin
        if (m_vs_prev && !vga_vs_n) start_clear(cyc + 2);
      end else begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    end
    m_vs_prev = vga_vs_n;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    q.delete();
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_pixel_GS", pixel_GS, 0);
    chk("rst_pixel_write", pixel_write, 0);
    chk("rst_oob_count", oob_count, 0);
    chk("rst_clear_busy", clear_busy, 0);
    m_mode = M_IDLE;
    m_last = NREQ - 1;
    m_oob  = 0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_until_idle();
    for (int i = 0; i < 4 * H_T * V_T && m_mode != M_IDLE; i++) step();
    chk("clear_finished", m_mode, M_IDLE);
  endtask

  initial forever begin
    @(negedge CLOCK_50);
    #2;
    if (!reset && pixel_write === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got x=%0d y=%0d gs=%0d at cycle %0d, expected no write",
                 x, y, pixel_GS, cyc);
      end else begin
        e_mon = q.pop_front();
        chk("wr_x", x, e_mon.x);
        chk("wr_y", y, e_mon.y);
        chk("wr_gs", pixel_GS, e_mon.gs);
        chk("wr_cycle", cyc, e_mon.cyc);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = '0; req_x = '0; req_y = '0; req_pixel = '0;
    clear_req = 1'b0; clear_sync = 1'b0; vga_vs_n = 1'b1; m_vs_prev = 1'b1;
    #5;
    do_reset();

    // fairness from reset: 0,1,2,0,1,2
    set_req(0, 1, 1, 10); set_req(1, 2, 2, 20); set_req(2, 3, 3, 30);
    req_valid = '1;
    repeat (6) step();
    req_valid = '0;
    step();

    // single write and in-range corner
    set_req(1, 4, 0, 127);
    req_valid = 3'b010;
    step();
    set_req(0, H_T - 1, V_T - 1, 200);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();

    // out-of-range drops, then saturation
    set_req(0, H_T, 10, 255);
    req_valid = 3'b001;
    step();
    set_req(0, 5, V_T, 255);
    step();
    req_valid = '0;
    step();
    chk("oob_two", oob_count, 2);
    set_req(0, 2000, 0, 1); set_req(1, 0, 2000, 2); set_req(2, H_T, V_T, 3);
    req_valid = '1;
    repeat (65540) step();
    req_valid = '0;
    step();
    chk("oob_saturated", oob_count, 16'hFFFF);

    // unsynced clear with a requester waiting throughout
    clear_req = 1'b1; clear_sync = 1'b0;
    step();
    clear_req = 1'b0;
    set_req(2, 7, 8, 99);
    req_valid = 3'b100;
    run_until_idle();
    step();
    req_valid = '0;
    repeat (2) step();

    // synced clear; a second request while waiting is ignored
    clear_req = 1'b1; clear_sync = 1'b1;
    step();
    clear_req = 1'b1; clear_sync = 1'b0;
    step();
    clear_req = 1'b0;
    repeat (20) step();
    vga_vs_n = 1'b0;
    repeat (5) step();
    vga_vs_n = 1'b1;
    run_until_idle();
    repeat (2) step();

    // reset partway through a clear
    clear_req = 1'b1; clear_sync = 1'b0;
    step();
    clear_req = 1'b0;
    repeat (10 * H_T + 5) step();
    do_reset();
    set_req(0, 1, 2, 3); set_req(1, 4, 5, 6); set_req(2, 7, 8, 9);
    req_valid = '1;
    repeat (3) step();
    req_valid = '0;
    step();

    // randomized traffic with occasional clears and a running vsync
    for (int i = 0; i < 4000; i++) begin
      req_valid = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++)
        set_req(r, int'($urandom_range(0, H_T + 2)), int'($urandom_range(0, V_T + 2)),
                int'($urandom_range(0, 255)));
      clear_req  = ($urandom_range(0, 399) == 0);
      clear_sync = 1'($urandom);
      vga_vs_n   = ((cyc % 150) < 140);
      step();
    end
    req_valid = '0; clear_req = 1'b0; vga_vs_n = 1'b1;
    if (m_mode == M_WAIT) begin
      vga_vs_n = 1'b0;
      step();
      vga_vs_n = 1'b1;
    end
    run_until_idle();
    repeat (3) step();
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Arbiter and sequencer for the single pixel write port of the 640x480 8-bit grayscale VGA framebuffer. Shares that port between NREQ drawing clients with round-robin valid/ready handshakes. Owns a built-in full-screen clear engine that can optionally start at the next vertical sync. Sits between the drawing blocks and the framebuffer's `x`, `y`, `pixel_GS`, `pixel_write` inputs.

## Interface
Parameters:
- NREQ, 3, number of drawing requesters (2..8)
- H_PIX, 640, visible width in pixels
- V_PIX, 480, visible height in lines
- CLEAR_VALUE, 8'h00, gray level written by the clear engine

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  requester i has a pixel to write
- req_x  in  NREQ*11  packed x coordinate, requester i at [11i+10:11i]
- req_y  in  NREQ*11  packed y coordinate, same packing
- req_pixel  in  NREQ*8  packed gray level
- req_ready  out  NREQ  one-hot grant; transfer occurs when valid&ready
- clear_req  in  1  single-cycle pulse requesting a full-screen clear
- clear_sync  in  1  sampled with clear_req; 1 = start the clear at the next VGA_VS falling edge
- vga_vs_n  in  1  framebuffer VGA_VS, same clock domain
- clear_busy  out  1  high while waiting for vsync or clearing
- x, y  out  11 each  write coordinates to the framebuffer
- pixel_GS  out  8  write data
- pixel_write  out  1  write strobe
- oob_count  out  16  saturating count of dropped out-of-range writes

## Operation
- FSM states: IDLE, WAIT_VS, CLEAR. Reset state is IDLE.
- IDLE:
  - Round-robin grant among asserted req_valid bits. Search starts at last_grant+1 mod NREQ.
  - req_ready is combinational, at most one bit high, and only in IDLE. It is zero when no requester is valid.
  - last_grant updates only on a transfer. Reset value is NREQ-1, so requester 0 has first priority.
- Out-of-range transfer (x>=H_PIX or y>=V_PIX):
  - The transfer is accepted, so ready is still given.
  - pixel_write stays 0.
  - oob_count increments and saturates at 16'hFFFF.
- clear_req in IDLE:
  - clear_sync=0: go to CLEAR.
  - clear_sync=1: go to WAIT_VS.
  - A grant issued in the same cycle still completes.
- clear_req in WAIT_VS or CLEAR is ignored. Clears are not queued.
- WAIT_VS: on a vga_vs_n 1->0 edge (compared against a registered copy of vga_vs_n), go to CLEAR.
- CLEAR:
  - Counters cx and cy start at 0.
  - Each cycle, write (cx, cy, CLEAR_VALUE).
  - cx increments and wraps at H_PIX-1. On wrap, cy increments.
  - After writing (H_PIX-1, V_PIX-1), return to IDLE.
- req_ready is all zero in WAIT_VS and CLEAR.
- clear_busy = (state != IDLE).
- Reset mid-clear returns to IDLE immediately. The clear is abandoned, the partial frame remains, and counters go to 0.

## Timing
- All outputs are registered. Reset value of every output is 0, including oob_count.
- Requester transfer in cycle n: x, y, pixel_GS and pixel_write are valid in cycle n+1 for exactly one cycle.
- Sustained throughput is one pixel per cycle, shared across requesters. With all NREQ requesters valid, each one gets one grant every NREQ cycles.
- Unsynced clear:
  - clear_req at cycle n → first write (0,0) at cycle n+2.
  - Last write (639,479) at cycle n+307201.
  - clear_busy is high from n+1 through n+307200.
  - IDLE grants resume at n+307201.
- Synced clear: the first write occurs 2 cycles after the vga_vs_n falling edge is seen.
- Write address arithmetic (y*640+x) belongs to the framebuffer, not this block.

## Structure
- Shared package fb_pkg:
  - Constants H_PIX=640, V_PIX=480, COORD_W=11, PIX_W=8.
  - typedef enum {IDLE, WAIT_VS, CLEAR} fbw_state_t.
  - typedef struct pixel_wr_t {x, y, gs}.
- Sub-module rr_arbiter:
  - Parameterized on N.
  - Inputs: req[N], advance.
  - Outputs: one-hot grant[N].
  - Holds the last_grant pointer.
  - Reusable for other shared resources.

## Test plan
- Single write: requester 1 valid with (4,0,127) → ready[1] the same cycle; next cycle x=4, y=0, pixel_GS=127, pixel_write=1 for one cycle.
- Fairness: requesters 0, 1 and 2 held valid for 6 cycles → grant order 0,1,2,0,1,2; six consecutive write strobes.
- Out of range: requester 0 sends (640,10,255), then (5,480,255) → both accepted, no pixel_write, oob_count=2. Then 65540 more drops → oob_count=16'hFFFF.
- Unsynced clear with CLEAR_VALUE=8'h00:
  - Exactly 307200 write strobes.
  - First write is (0,0); last write is (639,479).
  - req_ready stays 0 throughout.
  - A pending requester is granted the cycle after clear_busy falls.
- Synced clear: clear_sync=1 with vga_vs_n high → WAIT_VS with no writes. Drive vga_vs_n low → first clear write at edge+2.
- Reset mid-clear: assert reset at cy=100 → all outputs 0 and state IDLE immediately. After release, requester 0 is granted first.
